hazard_ctrl: RTL and testbench

//  Central stall/forward controller for the 5-stage MIPS pipeline (F/D/E/M/W).
//  Per-stage decoders supply register-use (Tuse) and result-ready (Tnew) data.
//  The block tracks each in-flight destination through E/M/W.
//  It drives the global stall, E-stage bubble insertion and all forwarding mux selects.
//  It also owns the mult/div (HI/LO) busy counter that blocks MDU-class instructions in D.

---
 rtl/hazard_ctrl_pkg.sv | 42 ++++
 rtl/hazard_ctrl_md_busy_counter.sv | 34 +++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, stage-tracking structs and helpers for the MIPS hazard controller.
package hazard_ctrl_pkg;

    // D-stage forward selects
    localparam logic [1:0] FWD_D_RF  = 2'b00;
    localparam logic [1:0] FWD_D_E   = 2'b01;
    localparam logic [1:0] FWD_D_M   = 2'b10;
    localparam logic [1:0] FWD_D_W   = 2'b11;
    // E-stage forward selects
    localparam logic [1:0] FWD_E_REG = 2'b00;
    localparam logic [1:0] FWD_E_M   = 2'b01;
    localparam logic [1:0] FWD_E_W   = 2'b10;

    localparam logic [1:0] MD_NONE   = 2'b00;
    localparam logic [1:0] MD_MULT   = 2'b01;
    localparam logic [1:0] MD_DIV    = 2'b10;
    localparam logic [1:0] MD_HILO   = 2'b11;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wreg;
        logic [1:0] tnew;
        logic [1:0] md_op;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] rt;
        logic [4:0] wreg;
        logic [1:0] tnew;
    } m_stage_t;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Mult/div busy counter: loads the op latency when an MDU op enters E, then
// counts down to zero and holds.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage MIPS pipeline: tracks destinations
// through E/M/W, compares against Tuse/Tnew and owns the HI/LO busy interlock.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wreg,
    input  logic [1:0] d_tnew,
    input  logic [1:0] d_md_op,
    output logic       stall,
    output logic       md_busy,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt
);

    e_stage_t   e_q, e_d;
    m_stage_t   m_q, m_d;
    logic [4:0] w_wreg_q, w_wreg_d;

    logic hz_rs, hz_rt, md_hazard, md_start, md_load, e_md_active;

    function automatic logic reg_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                        input e_stage_t e, input m_stage_t m);
        return (r != 5'd0) && (tuse != TUSE_NONE) &&
               ((e.wreg == r && e.tnew > tuse) || (m.wreg == r && m.tnew > tuse));
    endfunction

    // Youngest match wins; a younger match whose result is not ready yet
    // blocks older stages (the stall logic covers that case).
    function automatic logic [1:0] sel_d(input logic [4:0] r, input e_stage_t e,
                                         input m_stage_t m, input logic [4:0] w);
        if (r == 5'd0)     return FWD_D_RF;
        else if (e.wreg == r) return (e.tnew == 2'd0) ? FWD_D_E : FWD_D_RF;
        else if (m.wreg == r) return (m.tnew == 2'd0) ? FWD_D_M : FWD_D_RF;
        else if (w == r)   return FWD_D_W;
        else               return FWD_D_RF;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] r, input m_stage_t m,
                                         input logic [4:0] w);
        if (r == 5'd0)     return FWD_E_REG;
        else if (m.wreg == r) return (m.tnew == 2'd0) ? FWD_E_M : FWD_E_REG;
        else if (w == r)   return FWD_E_W;
        else               return FWD_E_REG;
    endfunction

    assign hz_rs = reg_hazard(d_rs, d_tuse_rs, e_q, m_q);
    assign hz_rt = reg_hazard(d_rt, d_tuse_rt, e_q, m_q);

    // An MDU op sitting in E has already loaded the counter; counting it
    // directly keeps the interlock independent of counter timing.
    assign md_start    = (d_md_op == MD_MULT) || (d_md_op == MD_DIV);
    assign e_md_active = (e_q.md_op == MD_MULT) || (e_q.md_op == MD_DIV);
    assign md_hazard   = (md_start || d_md_op == MD_HILO) && (md_busy || e_md_active);

    assign stall   = hz_rs | hz_rt | md_hazard;
    assign md_load = md_start && !stall;

    assign fwd_d_rs = sel_d(d_rs, e_q, m_q, w_wreg_q);
    assign fwd_d_rt = sel_d(d_rt, e_q, m_q, w_wreg_q);
    assign fwd_e_rs = sel_e(e_q.rs, m_q, w_wreg_q);
    assign fwd_e_rt = sel_e(e_q.rt, m_q, w_wreg_q);
    assign fwd_m_rt = (m_q.rt != 5'd0) && (m_q.rt == w_wreg_q);

    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.rs    = d_rs;
            e_d.rt    = d_rt;
            e_d.wreg  = d_wreg;
            e_d.tnew  = d_tnew;
            e_d.md_op = d_md_op;
        end
        m_d.rt   = e_q.rt;
        m_d.wreg = e_q.wreg;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_wreg_d = m_q.wreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_wreg_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            w_wreg_q <= w_wreg_d;
        end
    end

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (md_load),
        .is_div(d_md_op == MD_DIV),
        .busy  (md_busy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tur;
        logic [1:0] tut;
        logic [4:0] wreg;
        logic [1:0] tnew;
        logic [1:0] md;
    } din_t;

    typedef struct packed {
        logic       stall;
        logic       busy;
        logic [1:0] fdrs;
        logic [1:0] fdrt;
        logic [1:0] fers;
        logic [1:0] fert;
        logic       fmrt;
    } dout_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] d_rs = '0, d_rt = '0, d_wreg = '0;
    logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0, d_md_op = '0;
    logic       stall, md_busy, fwd_m_rt;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int n_cmp = 0;
    int n_err = 0;
    dout_t expq[$];
    string nameq[$];

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wreg(d_wreg), .d_tnew(d_tnew), .d_md_op(d_md_op),
        .stall(stall), .md_busy(md_busy),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
    );

    always #5 clk = ~clk;

    function automatic din_t I(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tur,
                               input logic [1:0] tut, input logic [4:0] wreg,
                               input logic [1:0] tnew, input logic [1:0] md);
        din_t d;
        d.rs = rs; d.rt = rt; d.tur = tur; d.tut = tut; d.wreg = wreg; d.tnew = tnew; d.md = md;
        return d;
    endfunction

    function automatic dout_t O(input logic st, input logic bz, input logic [1:0] fdrs,
                                input logic [1:0] fdrt, input logic [1:0] fers,
                                input logic [1:0] fert, input logic fmrt);
        dout_t o;
        o.stall = st; o.busy = bz; o.fdrs = fdrs; o.fdrt = fdrt;
        o.fers = fers; o.fert = fert; o.fmrt = fmrt;
        return o;
    endfunction

    task automatic step(input logic r, input din_t d, input dout_t e, input string nm);
        @(posedge clk);
        #1;
        reset = r;
        d_rs = d.rs; d_rt = d.rt; d_tuse_rs = d.tur; d_tuse_rt = d.tut;
        d_wreg = d.wreg; d_tnew = d.tnew; d_md_op = d.md;
        expq.push_back(e);
        nameq.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            dout_t e, a;
            string nm;
            e  = expq.pop_front();
            nm = nameq.pop_front();
            a  = {stall, md_busy, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got stall/busy/fdrs/fdrt/fers/fert/fmrt=%b want %b", nm, a, e);
            end
        end
    end

    din_t  NOP, MFHI, MULT, DIV, LW8, ADD8;
    dout_t Z, HELD;

    initial begin
        NOP  = I(0, 0, 3, 3, 0, 0, 0);
        MFHI = I(0, 0, 3, 3, 7, 1, 3);
        MULT = I(0, 0, 1, 1, 0, 0, 1);
        DIV  = I(0, 0, 1, 1, 0, 0, 2);
        LW8  = I(0, 8, 1, 3, 8, 2, 0);
        ADD8 = I(8, 0, 1, 1, 9, 1, 0);
        Z    = O(0, 0, 0, 0, 0, 0, 0);
        HELD = O(1, 1, 0, 0, 0, 0, 0);

        step(1, NOP, Z, "reset state");
        // lw $1 -> add reads $1: one stall, bubble, then W forward in E
        step(0, I(0, 1, 1, 3, 1, 2, 0), Z, "lw1 issue");
        step(0, I(1, 0, 1, 1, 3, 1, 0), O(1, 0, 0, 0, 0, 0, 0), "lw-use stall");
        step(0, I(1, 0, 1, 1, 3, 1, 0), Z, "add issues after stall");
        step(0, NOP, O(0, 0, 0, 0, 2, 0, 0), "add in E fwd W");
        // addu $2 in M, beq reads $2 in D
        step(0, I(0, 0, 1, 1, 2, 1, 0), Z, "addu2 issue");
        step(0, NOP, Z, "addu2 in E");
        step(0, I(2, 0, 0, 0, 0, 0, 0), O(0, 0, 2, 0, 0, 0, 0), "beq fwd M");
        // $2 in both E (tnew 1) and M (tnew 0)
        step(0, I(0, 0, 1, 1, 2, 1, 0), O(0, 0, 0, 0, 2, 0, 0), "beq in E fwd W");
        step(0, I(0, 0, 1, 1, 2, 1, 0), Z, "second addu2");
        step(0, I(2, 0, 0, 0, 0, 0, 0), O(1, 0, 0, 0, 0, 0, 0), "E blocks M stall");
        step(0, I(2, 0, 0, 0, 0, 0, 0), O(0, 0, 2, 0, 0, 0, 0), "beq fwd M after stall");
        // jal then jr $31
        step(0, I(0, 0, 3, 3, 31, 0, 0), O(0, 0, 0, 0, 2, 0, 0), "jal issue");
        step(0, I(31, 0, 0, 3, 0, 0, 0), O(0, 0, 1, 0, 0, 0, 0), "jr fwd E");
        // writes and reads of $0 never match
        step(0, I(0, 0, 1, 1, 0, 1, 0), O(0, 0, 0, 0, 1, 0, 0), "jr in E fwd M");
        step(0, I(0, 0, 1, 3, 0, 2, 0), Z, "lw to $0");
        step(0, I(0, 0, 0, 0, 4, 1, 0), Z, "read $0 no stall");
        // lw $5 / sw $5: store data via W in M
        step(0, I(0, 5, 1, 3, 5, 2, 0), Z, "lw5 issue");
        step(0, I(0, 5, 1, 2, 0, 0, 0), Z, "sw5 tuse2 no stall");
        step(0, NOP, Z, "sw5 in E blocked by M");
        step(0, NOP, O(0, 0, 0, 0, 0, 0, 1), "sw5 in M fwd W");
        // rt forwarding through M and W
        step(0, I(0, 0, 1, 1, 6, 1, 0), Z, "addu6 issue");
        step(0, NOP, Z, "addu6 in E");
        step(0, I(0, 6, 0, 0, 0, 0, 0), O(0, 0, 0, 2, 0, 0, 0), "rt fwd M");
        step(0, I(0, 6, 0, 0, 0, 0, 0), O(0, 0, 0, 3, 0, 2, 0), "rt fwd W in D and E");
        step(0, NOP, Z, "rt idle");
        // div: mfhi held exactly 10 cycles
        step(0, DIV, Z, "div issue");
        for (int i = 0; i < 10; i++) step(0, MFHI, HELD, "mfhi held by div");
        step(0, MFHI, Z, "mfhi issues after div");
        step(0, NOP, Z, "after mfhi");
        // mult: second mult held 5 cycles, then mfhi held 5
        step(0, MULT, Z, "mult issue");
        for (int i = 0; i < 5; i++) step(0, MULT, HELD, "mult held by mult");
        step(0, MULT, Z, "mult2 issues");
        for (int i = 0; i < 5; i++) step(0, MFHI, HELD, "mfhi held by mult");
        step(0, MFHI, Z, "mfhi issues after mult");
        step(0, NOP, Z, "after mfhi 2");
        // reset with counter at 7 and lw $8 in E
        step(0, DIV, Z, "div for reset");
        step(0, NOP, O(0, 1, 0, 0, 0, 0, 0), "busy cnt10");
        step(0, NOP, O(0, 1, 0, 0, 0, 0, 0), "busy cnt9");
        step(0, LW8, O(0, 1, 0, 0, 0, 0, 0), "lw8 issue cnt8");
        step(0, ADD8, O(1, 1, 0, 0, 0, 0, 0), "lw8 stall cnt7");
        #6 reset = 1'b1;
        step(1, ADD8, Z, "reset mid-op");
        step(0, NOP, Z, "after reset");

        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
